// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM encoding and data width for the ALU issue controller
package alu_pkg;

    localparam int DATA_W = 4;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_INC   = 4'd2;
    localparam logic [3:0] OP_DEC   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_NAND  = 4'd7;
    localparam logic [3:0] OP_NOR   = 4'd8;
    localparam logic [3:0] OP_XNOR  = 4'd9;
    localparam logic [3:0] OP_NOTA  = 4'd10;
    localparam logic [3:0] OP_NOTB  = 4'd11;
    localparam logic [3:0] OP_SHL   = 4'd12;
    localparam logic [3:0] OP_SHR   = 4'd13;
    localparam logic [3:0] OP_PASSA = 4'd14;
    localparam logic [3:0] OP_PASSB = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESULT
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_onehot_dec4.sv
// onehot_dec4: combinational 4-to-16 one-hot decoder for the function enables
module onehot_dec4
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0]        sel,
    output logic [(1<<DATA_W)-1:0]   y
);

    assign y = {{((1<<DATA_W)-1){1'b0}}, 1'b1} << sel;

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one ALU command, waits the settle time, captures and hands off the result
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [15:0]      alu_en,
    input  logic [3:0]       alu_y,
    input  logic             alu_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_data,
    output logic             res_zero,
    output logic             res_carry,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state, state_nx;
    logic [3:0]  settle_cnt;
    logic [15:0] dec_en;
    logic        accept, capture, res_done;

    onehot_dec4 u_dec (
        .sel (cmd_op),
        .y   (dec_en)
    );

    assign accept   = cmd_valid && cmd_ready;
    assign capture  = (state == ST_ISSUE) && (settle_cnt == 4'd0);
    assign res_done = (state == ST_RESULT) && res_ready;

    // next-state and command-side handshake; RESULT can take a new command on the release cycle
    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                state_nx  = cmd_valid ? ST_ISSUE : ST_IDLE;
            end
            ST_ISSUE:  state_nx = capture ? ST_RESULT : ST_ISSUE;
            ST_RESULT: begin
                cmd_ready = res_ready;
                state_nx  = res_ready ? (cmd_valid ? ST_ISSUE : ST_IDLE) : ST_RESULT;
            end
            default:   state_nx = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // operand/enable issue, settle countdown and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_en     <= '0;
            settle_cnt <= '0;
            res_data   <= '0;
            res_zero   <= 1'b0;
            res_carry  <= 1'b0;
        end else if (accept) begin
            alu_a      <= cmd_a;
            alu_b      <= cmd_b;
            alu_en     <= dec_en;
            settle_cnt <= SETTLE_LOAD;
        end else if (capture) begin
            alu_en     <= '0;
            res_data   <= alu_y;
            res_zero   <= (alu_y == 4'h0);
            res_carry  <= alu_cout;
        end else if (state == ST_ISSUE) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    // result-valid flag and completed-operation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            if (capture)       res_valid <= 1'b1;
            else if (res_done) res_valid <= 1'b0;
            if (res_done)      op_count  <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: two controller instances (settle 1 / 8-bit count, settle 3 / 2-bit count) against a transaction-level model
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       cmd_valid = 1'b0;
    logic       res_ready = 1'b0;
    logic [3:0] cmd_op = '0, cmd_a = '0, cmd_b = '0;

    logic        cr[2], ac[2], rv[2], rz[2], rc[2];
    logic [3:0]  aa[2], ab[2], ay[2], rd[2];
    logic [15:0] en[2];
    logic [7:0]  oc0;
    logic [1:0]  oc1;

    int checks = 0;
    int errors = 0;

    // reference function units: {cout, y}
    function automatic logic [4:0] alu_fn(int op, logic [3:0] a, logic [3:0] b);
        logic [4:0] r;
        case (op)
            0:  r = {1'b0, a} + {1'b0, b};
            1:  r = {1'b0, a} - {1'b0, b};
            2:  r = {1'b0, a} + 5'd1;
            3:  r = {1'b0, a} - 5'd1;
            4:  r = {1'b0, a & b};
            5:  r = {1'b0, a | b};
            6:  r = {1'b0, a ^ b};
            7:  r = {1'b0, ~(a & b)};
            8:  r = {1'b0, ~(a | b)};
            9:  r = {1'b0, ~(a ^ b)};
            10: r = {1'b0, ~a};
            11: r = {1'b0, ~b};
            12: r = {1'b0, a[2:0], 1'b0};
            13: r = {1'b0, 1'b0, a[3:1]};
            14: r = {1'b0, a};
            default: r = {1'b0, b};
        endcase
        return r;
    endfunction

    // OR-combined bus of all enabled units, as seen by the controller
    function automatic logic [4:0] alu_bus(logic [15:0] e, logic [3:0] a, logic [3:0] b);
        logic [4:0] r = '0;
        for (int n = 0; n < 16; n++)
            if (e[n]) r = r | alu_fn(n, a, b);
        return r;
    endfunction

    assign {ac[0], ay[0]} = alu_bus(en[0], aa[0], ab[0]);
    assign {ac[1], ay[1]} = alu_bus(en[1], aa[1], ab[1]);

    alu_issue_ctrl #(.SETTLE_CYCLES(1), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cr[0]),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(aa[0]), .alu_b(ab[0]), .alu_en(en[0]), .alu_y(ay[0]), .alu_cout(ac[0]),
        .res_valid(rv[0]), .res_ready(res_ready), .res_data(rd[0]), .res_zero(rz[0]),
        .res_carry(rc[0]), .op_count(oc0)
    );

    alu_issue_ctrl #(.SETTLE_CYCLES(3), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cr[1]),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(aa[1]), .alu_b(ab[1]), .alu_en(en[1]), .alu_y(ay[1]), .alu_cout(ac[1]),
        .res_valid(rv[1]), .res_ready(res_ready), .res_data(rd[1]), .res_zero(rz[1]),
        .res_carry(rc[1]), .op_count(oc1)
    );

    // transaction model: a command in flight ages until its settle time, then becomes a pending result
    int         settle[2] = '{1, 3};
    int         cnt_mod[2] = '{256, 4};
    bit         m_busy[2], m_has[2], m_z[2], m_c[2];
    int         m_age[2], m_cnt[2];
    logic [3:0] m_op[2], m_a[2], m_b[2], m_res[2];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_has[i] = 0; m_z[i] = 0; m_c[i] = 0;
            m_age[i] = 0; m_cnt[i] = 0;
            m_op[i] = '0; m_a[i] = '0; m_b[i] = '0; m_res[i] = '0;
        end
    endtask

    task automatic compare();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("cmd_ready%0d", i), 32'(cr[i]), 32'(!m_busy[i] && (!m_has[i] || res_ready)));
            chk($sformatf("alu_en%0d", i), 32'(en[i]), m_busy[i] ? 32'(1) << m_op[i] : 32'd0);
            chk($sformatf("alu_a%0d", i), 32'(aa[i]), 32'(m_a[i]));
            chk($sformatf("alu_b%0d", i), 32'(ab[i]), 32'(m_b[i]));
            chk($sformatf("res_valid%0d", i), 32'(rv[i]), 32'(m_has[i]));
            if (m_has[i]) begin
                chk($sformatf("res_data%0d", i), 32'(rd[i]), 32'(m_res[i]));
                chk($sformatf("res_zero%0d", i), 32'(rz[i]), 32'(m_z[i]));
                chk($sformatf("res_carry%0d", i), 32'(rc[i]), 32'(m_c[i]));
            end
            chk($sformatf("op_count%0d", i), i == 0 ? 32'(oc0) : 32'(oc1), 32'(m_cnt[i]));
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (m_busy[i]) begin
                if (m_age[i] == settle[i] - 1) begin
                    {m_c[i], m_res[i]} = alu_fn(int'(m_op[i]), m_a[i], m_b[i]);
                    m_z[i] = (m_res[i] == 4'h0);
                    m_has[i] = 1;
                    m_busy[i] = 0;
                end else m_age[i]++;
            end else begin
                bit take = cmd_valid && (!m_has[i] || res_ready);
                if (m_has[i] && res_ready) begin
                    m_cnt[i] = (m_cnt[i] + 1) % cnt_mod[i];
                    m_has[i] = 0;
                end
                if (take) begin
                    m_busy[i] = 1; m_age[i] = 0;
                    m_op[i] = cmd_op; m_a[i] = cmd_a; m_b[i] = cmd_b;
                end
            end
        end
    endtask

    task automatic step(bit v, logic [3:0] op, logic [3:0] a, logic [3:0] b, bit rr);
        @(negedge clk);
        cmd_valid = v; cmd_op = op; cmd_a = a; cmd_b = b; res_ready = rr;
        #1;
        compare();
        model_update();
    endtask

    task automatic do_reset();
        cmd_valid = 0; res_ready = 0;
        rst_n = 0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_en%0d", i), 32'(en[i]), 32'd0);
            chk($sformatf("rst_valid%0d", i), 32'(rv[i]), 32'd0);
            chk($sformatf("rst_data%0d", i), 32'({rd[i], rz[i], rc[i]}), 32'd0);
            chk($sformatf("rst_ops%0d", i), 32'({aa[i], ab[i]}), 32'd0);
        end
        chk("rst_count", 32'({oc0, oc1}), 32'd0);
        compare();
        @(negedge clk);
        rst_n = 1;
    endtask

    int on_cnt;

    initial begin
        do_reset();

        // single NAND
        step(1, OP_NAND, 4'h1, 4'h1, 0);
        chk("nand_ready", 32'(cr[0]), 32'd1);
        step(0, 4'h0, 4'h0, 4'h0, 0);
        chk("nand_en", 32'(en[0]), 32'h0080);
        step(0, 4'h0, 4'h0, 4'h0, 0);
        chk("nand_valid", 32'(rv[0]), 32'd1);
        chk("nand_data", 32'(rd[0]), 32'hE);
        chk("nand_zero", 32'(rz[0]), 32'd0);
        chk("nand_en_off", 32'(en[0]), 32'd0);
        chk("nand_en_s3", 32'(en[1]), 32'h0080);

        // zero and carry flags
        do_reset();
        step(1, OP_ADD, 4'hF, 4'h1, 0);
        step(0, 4'h0, 4'h0, 4'h0, 0);
        step(0, 4'h0, 4'h0, 4'h0, 0);
        chk("add_data", 32'(rd[0]), 32'h0);
        chk("add_zero", 32'(rz[0]), 32'd1);
        chk("add_carry", 32'(rc[0]), 32'd1);
        for (int t = 0; t < 3; t++) step(0, 4'h0, 4'h0, 4'h0, 0);
        chk("add_carry_s3", 32'({rv[1], rz[1], rc[1]}), 32'b111);

        // back-to-back with res_ready high
        do_reset();
        for (int t = 0; t <= 7; t++) begin
            step(t <= 4, 4'($urandom), 4'($urandom), 4'($urandom), 1);
            if (t >= 2 && t <= 6) chk($sformatf("b2b_valid_t%0d", t), 32'(rv[0]), 32'((t % 2) == 0));
        end
        chk("b2b_count", 32'(oc0), 32'd3);

        // backpressure
        do_reset();
        step(1, OP_XOR, 4'h5, 4'h3, 0);
        step(0, 4'h0, 4'h0, 4'h0, 0);
        for (int t = 0; t < 10; t++) begin
            step(1, OP_OR, 4'h8, 4'h1, 0);
            chk("bp_ready", 32'(cr[0]), 32'd0);
            chk("bp_data", 32'(rd[0]), 32'h6);
        end
        step(1, OP_OR, 4'h8, 4'h1, 1);
        chk("bp_release_ready", 32'(cr[0]), 32'd1);
        step(0, 4'h0, 4'h0, 4'h0, 0);
        chk("bp_next_en", 32'(en[0]), 32'h0020);

        // settle time of 3
        do_reset();
        step(1, OP_SUB, 4'h2, 4'h7, 0);
        on_cnt = 0;
        for (int t = 0; t < 6; t++) begin
            step(0, 4'h0, 4'h0, 4'h0, 0);
            if (en[1] != 16'h0) on_cnt++;
        end
        chk("settle3_cycles", 32'(on_cnt), 32'd3);

        // counter wrap with a 2-bit counter
        do_reset();
        for (int t = 0; t <= 21; t++)
            step(t <= 16, 4'($urandom), 4'($urandom), 4'($urandom), 1);
        chk("wrap_count", 32'(oc1), 32'd1);

        // reset in the middle of ISSUE
        do_reset();
        step(1, OP_INC, 4'h4, 4'h0, 0);
        step(0, 4'h0, 4'h0, 4'h0, 0);
        chk("mid_issue_en", 32'(en[1]), 32'h0004);
        do_reset();
        for (int t = 0; t < 6; t++) step(0, 4'h0, 4'h0, 4'h0, 1);

        // randomized traffic
        for (int t = 0; t < 3000; t++)
            step($urandom_range(0, 9) < 7, 4'($urandom), 4'($urandom), 4'($urandom),
                 $urandom_range(0, 9) < 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
